// File: rtl/am_stat_pkg.sv
// Shared state encoding and derived-width helpers for the approximate-multiplier error collector.
package am_stat_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int calc_cnt_w(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

  // Wide enough for n_samples worst-case errors of (2^(2*width)-1) each.
  function automatic int calc_sum_w(input int width, input int n_samples);
    return 2 * width + calc_cnt_w(n_samples);
  endfunction

endpackage

// File: rtl/am_err_stage.sv
// Two-stage error pipe: S1 registers the sample, S2 registers |z - x*y| and the mismatch flag.
// Latency 2 cycles from valid to err_valid; no stall path, the caller only feeds it while it can drain.
module am_err_stage #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] z,
  output logic               s1_valid,
  output logic               err_valid,
  output logic [2*WIDTH-1:0] err,
  output logic               mismatch
);

  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [2*WIDTH-1:0] z_q;
  logic [2*WIDTH-1:0] prod;

  assign prod = (2*WIDTH)'(x_q) * (2*WIDTH)'(y_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      s1_valid  <= valid;
      err_valid <= s1_valid;
    end
  end

  // Data registers only load on a valid beat; downstream qualifies them with the valid bits.
  always_ff @(posedge clk) begin
    if (valid) begin
      x_q <= x;
      y_q <= y;
      z_q <= z;
    end
    if (s1_valid) begin
      err      <= (z_q >= prod) ? (z_q - prod) : (prod - z_q);
      mismatch <= (z_q != prod);
    end
  end

endmodule

// File: rtl/am_error_stats.sv
// Run-statistics collector for an 8x8 approximate multiplier: counts, error sum, error max over N_SAMPLES.
// Statistics trail a transfer by 3 edges; in_ready is high only while a run is accepting samples.
module am_error_stats
  import am_stat_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = calc_cnt_w(N_SAMPLES),
  parameter int SUM_W     = calc_sum_w(WIDTH, N_SAMPLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [2*WIDTH-1:0] in_z,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   sum_abs_err,
  output logic [2*WIDTH-1:0] max_abs_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t             state;
  logic               xfer;
  logic               s1_valid;
  logic               err_valid;
  logic               mismatch;
  logic [2*WIDTH-1:0] err;

  assign xfer = in_valid & in_ready;

  am_err_stage #(.WIDTH(WIDTH)) u_err_stage (
    .clk       (clk),
    .rst       (rst),
    .valid     (xfer),
    .x         (in_x),
    .y         (in_y),
    .z         (in_z),
    .s1_valid  (s1_valid),
    .err_valid (err_valid),
    .err       (err),
    .mismatch  (mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else begin
      done <= 1'b0;

      if (err_valid) begin
        sum_abs_err <= sum_abs_err + SUM_W'(err);
        err_cnt     <= err_cnt + CNT_W'(mismatch);
        if (err > max_abs_err) max_abs_err <= err;
      end

      // The pipe is never valid in IDLE, so the clear on start cannot race an accumulate.
      case (state)
        IDLE: if (start) begin
          state       <= RUN;
          in_ready    <= 1'b1;
          busy        <= 1'b1;
          sample_cnt  <= '0;
          err_cnt     <= '0;
          sum_abs_err <= '0;
          max_abs_err <= '0;
        end
        RUN: if (xfer) begin
          sample_cnt <= sample_cnt + 1'b1;
          if (sample_cnt == LAST_IDX) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        // Once S1 is empty the last sample accumulates on this same edge.
        DRAIN: if (!s1_valid) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am_error_stats.sv
// Randomized bench: four collector instances (N = 16, 1, 2, 65536) on a shared sample bus,
// each run scored against an abs-error model computed from the queued samples.
module tb_am_error_stats;

  localparam int NS [4] = '{16, 1, 2, 65536};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start;
  logic        in_valid;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [15:0] in_z;

  logic        rdy [4];
  logic        bsy [4];
  logic        dn  [4];
  logic [63:0] o_cnt [4];
  logic [63:0] o_err [4];
  logic [63:0] o_sum [4];
  logic [63:0] o_max [4];

  int done_cnt [4] = '{0, 0, 0, 0};
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  qx [$];
  logic [7:0]  qy [$];
  logic [15:0] qz [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = $clog2(NS[g] + 1);
    localparam int SW = 16 + CW;
    logic [CW-1:0] sc;
    logic [CW-1:0] ec;
    logic [SW-1:0] sm;
    logic [15:0]   mx;

    am_error_stats #(.WIDTH(8), .N_SAMPLES(NS[g])) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[g]),
      .in_valid    (in_valid),
      .in_ready    (rdy[g]),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_z        (in_z),
      .busy        (bsy[g]),
      .done        (dn[g]),
      .sample_cnt  (sc),
      .err_cnt     (ec),
      .sum_abs_err (sm),
      .max_abs_err (mx)
    );

    assign o_cnt[g] = 64'(sc);
    assign o_err[g] = 64'(ec);
    assign o_sum[g] = 64'(sm);
    assign o_max[g] = 64'(mx);
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!rst && dn[i]) done_cnt[i]++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [15:0] z);
    qx.push_back(x);
    qy.push_back(y);
    qz.push_back(z);
  endtask

  task automatic clear_q();
    qx.delete();
    qy.delete();
    qz.delete();
  endtask

  // One complete run on instance sel using the queued samples; bubbles and a stray start are optional.
  task automatic run(input int sel, input int bubble_pct, input bit mid_start, input string tag);
    int          n;
    int          idx;
    int          cyc;
    int          lat;
    int          d0;
    bit          ms_done;
    bit          go;
    logic [63:0] p;
    logic [63:0] d;
    logic [63:0] esum;
    logic [63:0] eerr;
    logic [63:0] emax;

    n    = qx.size();
    esum = 0;
    eerr = 0;
    emax = 0;
    for (int i = 0; i < n; i++) begin
      p = 64'(qx[i]) * 64'(qy[i]);
      d = (64'(qz[i]) > p) ? 64'(qz[i]) - p : p - 64'(qz[i]);
      esum += d;
      if (d != 0) eerr++;
      if (d > emax) emax = d;
    end

    d0 = done_cnt[sel];
    @(negedge clk);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    check({tag, "_ready_on"}, 64'(rdy[sel]), 64'd1);
    check({tag, "_busy_on"}, 64'(bsy[sel]), 64'd1);
    check({tag, "_clr_cnt"}, o_cnt[sel], 64'd0);
    check({tag, "_clr_sum"}, o_sum[sel], 64'd0);

    idx     = 0;
    cyc     = 0;
    ms_done = 1'b0;
    while (idx < n && cyc < 4 * n + 100) begin
      start[sel] = mid_start && !ms_done && (idx == n / 2);
      if (start[sel]) ms_done = 1'b1;
      if (bubble_pct > 0 && $urandom_range(99) < 32'(bubble_pct)) begin
        in_valid = 1'b0;
        in_x     = 8'($urandom);
        in_y     = 8'($urandom);
        in_z     = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_x     = qx[idx];
        in_y     = qy[idx];
        in_z     = qz[idx];
      end
      go = in_valid && rdy[sel];
      @(posedge clk);
      if (go) idx++;
      @(negedge clk);
      cyc++;
    end
    start[sel] = 1'b0;
    in_valid   = 1'b0;
    check({tag, "_xfers"}, 64'(idx), 64'(n));
    check({tag, "_drain_busy"}, 64'(bsy[sel]), 64'd1);
    check({tag, "_drain_ready"}, 64'(rdy[sel]), 64'd0);

    lat = 1;
    while (!dn[sel] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_latency"}, 64'(lat), 64'd3);
    check({tag, "_sample_cnt"}, o_cnt[sel], 64'(n));
    check({tag, "_err_cnt"}, o_err[sel], eerr);
    check({tag, "_sum"}, o_sum[sel], esum);
    check({tag, "_max"}, o_max[sel], emax);

    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(dn[sel]), 64'd0);
    check({tag, "_idle_busy"}, 64'(bsy[sel]), 64'd0);
    check({tag, "_sum_hold"}, o_sum[sel], esum);
    check({tag, "_done_count"}, 64'(done_cnt[sel] - d0), 64'd1);
  endtask

  initial begin
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
    int          d0;

    rst      = 1'b1;
    start    = '0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_z     = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_ready", 64'(rdy[i]), 64'd0);
      check("rst_busy", 64'(bsy[i]), 64'd0);
      check("rst_done", 64'(dn[i]), 64'd0);
      check("rst_cnt", o_cnt[i], 64'd0);
      check("rst_sum", o_sum[i] | o_err[i] | o_max[i], 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    clear_q();
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      push(x, y, 16'(x) * 16'(y));
    end
    run(0, 0, 1'b0, "exact16");

    clear_q();
    push(8'd255, 8'd255, 16'd0);
    run(1, 0, 1'b0, "max1");
    check("max1_sum_const", o_sum[1], 64'd65025);

    clear_q();
    push(8'd3, 8'd5, 16'd20);
    push(8'd4, 8'd4, 16'd10);
    run(2, 0, 1'b0, "pair");
    check("pair_sum_const", o_sum[2], 64'd11);
    check("pair_max_const", o_max[2], 64'd6);
    run(2, 50, 1'b1, "pair_gaps");

    // Mixed exact, near-miss and wild outputs with bubbles.
    for (int r = 0; r < 4; r++) begin
      clear_q();
      for (int i = 0; i < 16; i++) begin
        x = 8'($urandom);
        y = 8'($urandom);
        p = 16'(x) * 16'(y);
        case ($urandom_range(2))
          0:       push(x, y, p);
          1:       push(x, y, p + 16'($urandom_range(15)) - 16'd7);
          default: push(x, y, 16'($urandom));
        endcase
      end
      run(0, 30, r == 1, "rand");
    end

    // Abort a run with reset after five transfers.
    d0 = done_cnt[0];
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_x = 8'($urandom_range(255, 1));
      in_y = 8'($urandom_range(255, 1));
      in_z = 16'd0;
      @(negedge clk);
    end
    check("abort_pre_cnt", o_cnt[0], 64'd5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(rdy[0]), 64'd0);
    check("abort_busy", 64'(bsy[0]), 64'd0);
    check("abort_cnt", o_cnt[0], 64'd0);
    check("abort_err", o_err[0], 64'd0);
    check("abort_sum", o_sum[0], 64'd0);
    check("abort_max", o_max[0], 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);

    clear_q();
    for (int i = 0; i < 65536; i++) push(8'(i >> 8), 8'(i), 16'd0);
    run(3, 0, 1'b0, "sweep");
    check("sweep_sum_const", o_sum[3], 64'd1065369600);
    check("sweep_err_const", o_err[3], 64'd65025);
    check("sweep_cnt_const", o_cnt[3], 64'd65536);
    check("sweep_max_const", o_max[3], 64'd65025);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
